// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Holds the fetch PC, issues word reads to instruction memory under a credit
// limit, buffers in-order responses in a small queue and presents {pc, instr}
// to decode. A redirect flushes the queue and marks every in-flight fetch for
// discard, so only instructions from the new path ever reach decode.
//
// Handshake rule used on every interface: a transfer happens on a rising edge
// where valid && ready are both 1. The producer holds valid and payload stable
// until the transfer. The only exception is the request channel, which is
// withdrawn in a redirect cycle. ready may depend on valid, but valid never
// depends on ready.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory request channel
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  // instruction memory response channel (in order, never stalls)
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  // branch/jump redirect from execute
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // decode-side channel
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  // Counters hold 0..QDEPTH, so they need one bit more than the pointers.
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [CW:0]   QD_EXT  = (CW + 1)'(QDEPTH);
  localparam logic [CW-1:0] QD_CNT  = CW'(QDEPTH);
  localparam logic [31:0]   PC_INIT = {RESET_PC[31:2], 2'b00};

  // Architectural fetch state
  logic [31:0]   fetch_pc;
  // outstanding counts every accepted request whose response has not yet
  // returned. discard counts how many of the oldest of those belong to a
  // squashed path. Invariant: discard <= outstanding.
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  // Fetch queue storage and control
  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] q_count;

  // Per-cycle control
  logic [CW:0]   credit_used;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   out_bytes;
  logic [31:0]   rsp_pc;
  logic [31:0]   redirect_target;
  logic [1:0]    unused_redirect_lo;

  // The two low redirect bits are ignored: targets are always word aligned.
  assign unused_redirect_lo = redirect_pc[1:0];
  assign redirect_target    = {redirect_pc[31:2], 2'b00};

  // Credit check, handshakes and the PC that belongs to an arriving response.
  // Live (non-discarded) requests are contiguous words ending just below
  // fetch_pc. A response is only kept when discard is zero, and then every
  // outstanding request is live, so the oldest one sits at
  // fetch_pc - 4*outstanding. Subtraction wraps the same way the PC does.
  always_comb begin
    credit_used    = {1'b0, outstanding} + {1'b0, q_count};
    imem_req_valid = !rst && !redirect_valid && (credit_used < QD_EXT);
    imem_req_addr  = fetch_pc;
    accept         = imem_req_valid && imem_req_ready;

    id_valid       = !rst && (q_count != '0);
    id_instr       = q_instr[rd_ptr];
    id_pc          = q_pc[rd_ptr];

    // A redirect squashes the same-cycle response and ignores the pop.
    push           = imem_rsp_valid && !redirect_valid && (discard == '0);
    pop            = id_valid && id_ready && !redirect_valid;

    out_bytes      = 32'(outstanding) << 2;
    rsp_pc         = fetch_pc - out_bytes;
  end

  // Fetch PC: reset, redirect, or advance by one word on an accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= PC_INIT;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
    end else if (accept) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // In-flight bookkeeping. Every response retires one outstanding request,
  // including a response that arrives during a redirect. On a redirect, all
  // requests still in flight after this cycle's response belong to the old
  // path. Setting discard to exactly that number keeps back-to-back
  // redirects exact, because requests already marked are not counted twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        discard <= outstanding - CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
    end
  end

  // Queue pointers and occupancy. Both reset and redirect flush the queue.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

  // Queue payload. Entries become visible to decode on the cycle after the write.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= rsp_pc;
      q_instr[wr_ptr] <= imem_rsp_data;
    end
  end

  // Design-error checks. The credit scheme should make these unreachable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (q_count == QD_CNT)));
      assert (!(imem_rsp_valid && (outstanding == '0)));
      assert (outstanding <= QD_CNT);
      assert (discard <= outstanding);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard. The stimulus pushes the
// expected {pc, instr} pairs and a separate monitor pops and compares them on
// every decode handshake. A behavioural memory returns word ^ KEY after a
// fixed latency and drops its in-flight requests on reset.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] KEY    = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t       mem_q[$];
  logic [31:0] acc_log[$];
  int          acc_count = 0;
  int          cyc       = 0;
  int          lat       = 1;

  instr_fetch #(
    .RESET_PC (RST_PC),
    .QDEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc);
    exp_q.push_back({pc, instr_of(pc)});
  endtask

  // Memory model: drive a response at each negedge, then capture the accept
  // that the next posedge will perform.
  initial begin : memory
    mreq_t m;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        m = mem_q.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(m.addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      #1;
      if (rst) begin
        mem_q.delete();
        acc_log.delete();
        acc_count = 0;
      end else if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
        acc_log.push_back(imem_req_addr);
        acc_count++;
      end
      cyc++;
    end
  end

  // Monitor: pop and compare on every decode handshake that the DUT honours.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && !redirect_valid && id_valid && id_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pop: got pc=%h instr=%h, expected nothing", id_pc, id_instr);
        end else begin
          e = exp_q.pop_front();
          if ({id_pc, id_instr} !== e) begin
            failures++;
            $display("FAIL id_out: got pc=%h instr=%h expected pc=%h instr=%h",
                     id_pc, id_instr, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  // Driver tasks. Each is entered at a negedge and returns at a negedge.
  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    #4;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    check("post_rst_id_valid", 32'(id_valid), 32'd0);
    check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_rst_req_addr", imem_req_addr, RST_PC);
    @(negedge clk);
  endtask

  task automatic wait_acc(input int n, input int max);
    int t = 0;
    while (acc_count < n && t < max) begin
      @(negedge clk);
      t++;
    end
    if (acc_count < n) begin
      checks++;
      failures++;
      $display("FAIL wait_acc: got=%0d accepts expected=%0d", acc_count, n);
    end
  endtask

  task automatic drain(input string name, input int max);
    int t = 0;
    id_ready = 1'b1;
    while (exp_q.size() != 0 && t < max) begin
      @(negedge clk);
      t++;
    end
    id_ready = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain: got %0d entries left expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // stimulus
  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    imem_req_ready = 1'b1;

    // 1/5: streaming from RESET_PC=FFFF_FFF8, 1-cycle memory, PC wraps to 0
    lat = 1;
    do_reset();
    for (int i = 0; i < 6; i++) exp_push(RST_PC + 32'(i * 4));
    drain("t1", 40);
    check("t1_req_addr0", acc_log[0], 32'hFFFF_FFF8);
    check("t1_req_addr1", acc_log[1], 32'hFFFF_FFFC);
    check("t1_req_addr2", acc_log[2], 32'h0000_0000);

    // 2: decode stalled for 10 cycles -> exactly QDEPTH accepts, then drain
    lat = 1;
    do_reset();
    repeat (10) @(negedge clk);
    #4;
    check("t2_accepts", 32'(acc_count), 32'd2);
    check("t2_req_valid", 32'(imem_req_valid), 32'd0);
    check("t2_id_valid", 32'(id_valid), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) exp_push(RST_PC + 32'(i * 4));
    drain("t2", 40);
    check("t2_resume_addr", acc_log[2], 32'h0000_0000);

    // 3: redirect to 0x103 with two requests in flight on a 3-cycle memory
    lat = 3;
    do_reset();
    wait_acc(2, 20);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #4;
    check("t3_redir_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #4;
    check("t3_flush_id_valid", 32'(id_valid), 32'd0);
    @(negedge clk);
    exp_push(32'h0000_0100);
    exp_push(32'h0000_0104);
    drain("t3", 40);
    check("t3_new_req_addr", acc_log[2], 32'h0000_0100);

    // 4: redirect coinciding with a response and a decode pop
    lat = 1;
    do_reset();
    wait_acc(2, 20);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    id_ready       = 1'b1;
    #4;
    check("t4_pre_id_valid", 32'(id_valid), 32'd1);
    check("t4_redir_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    #4;
    check("t4_flush_id_valid", 32'(id_valid), 32'd0);
    check("t4_req_valid", 32'(imem_req_valid), 32'd1);
    check("t4_req_addr", imem_req_addr, 32'h0000_2000);
    @(negedge clk);
    exp_push(32'h0000_2000);
    exp_push(32'h0000_2004);
    drain("t4", 40);

    // 6: reset with a full queue, then restart from RESET_PC
    lat = 1;
    do_reset();
    repeat (6) @(negedge clk);
    #4;
    check("t6_full_id_valid", 32'(id_valid), 32'd1);
    check("t6_full_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    do_reset();
    exp_push(RST_PC);
    exp_push(RST_PC + 32'd4);
    drain("t6", 40);

    // back-to-back redirects: the last one wins, old responses all dropped
    lat = 3;
    do_reset();
    wait_acc(2, 20);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    @(negedge clk);
    redirect_pc    = 32'h0000_0400;
    #4;
    check("t7_redir_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_push(32'h0000_0400);
    exp_push(32'h0000_0404);
    drain("t7", 40);
    check("t7_new_req_addr", acc_log[2], 32'h0000_0400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
